instr_encoder_loader: RTL
=========================

Name: instr_encoder_loader

Overview:
- Inverse of the core's instruction decoder. Accepts a stream of decoded-instruction tuples (class, ALUOp code, registers, immediate) over a valid/ready handshake.
- Packs each tuple into a 32-bit RV32I word and writes the words sequentially into instruction memory through a write port, starting at word 0.
- Appends a halt word when the stream ends. Used by the bench and by the boot loader to build programs for the single-cycle core.

Parameters:
- DEPTH, 256, instruction memory size in 32-bit words (2..65535); the last available slot is reserved for the halt word.
- ADDR_W, 32, width of the byte address on imem_addr.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load session.
- op_valid  in  1  tuple valid.
- op_ready  out  1  block accepts the tuple this cycle.
- op_last  in  1  tuple is the final one of the session.
- op_cls  in  3  0=R, 1=I-ALU, 2=LOAD(lw), 3=STORE(sw), 4=BRANCH; 5..7 illegal.
- op_alu  in  4  ALUOp code: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra, 8 slt, 9 sltu. For BRANCH, bits[2:0] are the branch funct3.
- op_rd, op_rs1, op_rs2  in  5 each  register indices.
- op_imm  in  13  signed immediate; branches use a byte offset.
- imem_we  out  1  write strobe.
- imem_addr  out  ADDR_W  byte address, always word-aligned.
- imem_wdata  out  32  encoded word.
- busy  out  1  state is RUN or FLUSH.
- done  out  1  session complete.
- err  out  1  sticky: at least one illegal tuple was dropped.
- overflow  out  1  sticky: the session was truncated by capacity.
- word_count  out  16  words written this session, including the halt word.

Behaviour:
- Reset: every output is 0 and the state is IDLE. Reset mid-session aborts it immediately; a partially written program is left in memory.
- States:
  - IDLE: start goes to RUN. Entering RUN clears the address, word_count, err and overflow.
  - RUN: op_ready = (word_count < DEPTH-1). A handshake (op_valid & op_ready) accepts one tuple.
  - FLUSH: exactly one cycle. Writes the halt word 0x0000006F (jal x0,0) at byte address word_count*4, then goes to DONE.
  - DONE: done=1. start returns to RUN with the same clearing as from IDLE.
- start is ignored in RUN and FLUSH.
- Transitions out of RUN:
  - An accepted tuple with op_last=1 (legal or not) goes to FLUSH.
  - After the accepted legal tuple that brings word_count to DEPTH-1 without op_last: set overflow, go to FLUSH; op_ready is 0 from the next cycle.
  - If both occur together, go to FLUSH and set overflow.
- Latency:
  - A legal tuple accepted in cycle N gives imem_we=1 in cycle N+1, with registered addr/wdata; word_count increments at the same edge.
  - Throughput is one tuple per cycle. Memory never stalls.
- Illegal tuples are accepted and consumed, produce no write, and set err. Illegal cases:
  - op_cls 5..7.
  - op_alu > 9 for R or I.
  - I with op_alu = 1 (no subi).
  - op_imm outside the 12-bit signed range (imm[12] != imm[11]) for I, LOAD or STORE.
  - BRANCH with op_imm[0]=1, op_alu[3]=1, or op_alu[2:0] equal to 010 or 011.
- Encoding (f3/f7 follow the core's ALUOp decode: add/sub 000, sll 001, slt 010, sltu 011, xor 100, srl/sra 101, or 110, and 111; f7 = 0100000 for sub and sra, otherwise 0):
  - R: {f7, rs2, rs1, f3, rd, 0110011}.
  - I: {imm[11:0], rs1, f3, rd, 0010011}. For shifts: {f7, imm[4:0], rs1, f3, rd, 0010011}.
  - LOAD: {imm[11:0], rs1, 010, rd, 0000011}.
  - STORE: {imm[11:5], rs2, rs1, 010, imm[4:0], 0100011}.
  - BRANCH: {imm[12], imm[10:5], rs2, rs1, alu[2:0], imm[4:1], imm[11], 1100011}.
- Fields that a class does not use are ignored.

Test Plan:
- Reset then start; send add x3,x1,x2 (cls0, alu0, rd3, rs1 1, rs2 2) with op_last=1. Expect write 0x002081B3 @0x0, then 0x0000006F @0x4; done=1, word_count=2.
- Send back-to-back, one per cycle: addi x1,x0,5; sw x2,8(x1); srai x5,x6,3; beq x1,x2,-8 (last). Expect writes 0x00500093, 0x0020A423, 0x40335293, 0xFE208CE3, then the halt word, on consecutive cycles at addresses 0x0 through 0x10.
- Send an illegal tuple (cls1, alu1) between two legal ones. Expect it consumed with no write, err=1, and the addresses of the legal words contiguous.
- DEPTH=4: send 5 tuples with no op_last. Expect op_ready low after the third accept, overflow=1, halt word @0xC, word_count=4.
- Assert rst asynchronously mid-RUN. Expect all outputs 0 immediately. A new start then writes again from address 0 with err and overflow cleared.
- Pulse start during RUN. Expect it ignored, with no change to address or word_count.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// Packs decoded-instruction tuples into RV32I words and streams them into
// instruction memory from word 0, terminating each session with a halt word.
module instr_encoder_loader #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic              op_last,
  input  logic [2:0]        op_cls,
  input  logic [3:0]        op_alu,
  input  logic [4:0]        op_rd,
  input  logic [4:0]        op_rs1,
  input  logic [4:0]        op_rs2,
  input  logic [12:0]       op_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              overflow,
  output logic [15:0]       word_count
);

  localparam int unsigned WC_W = 16;
  localparam logic [WC_W-1:0] LAST_SLOT = WC_W'(DEPTH - 1);
  localparam logic [31:0] HALT_WORD = 32'h0000_006F;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t state, state_nxt;

  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        imm_fits;
  logic        is_shift;
  logic        legal;
  logic [31:0] enc;

  // ALUOp code to funct3/funct7, matching the core's decoder
  always_comb begin
    f3 = 3'b000;
    f7 = 7'b0000000;
    case (op_alu)
      4'd0: f3 = 3'b000;
      4'd1: begin f3 = 3'b000; f7 = 7'b0100000; end
      4'd2: f3 = 3'b111;
      4'd3: f3 = 3'b110;
      4'd4: f3 = 3'b100;
      4'd5: f3 = 3'b001;
      4'd6: f3 = 3'b101;
      4'd7: begin f3 = 3'b101; f7 = 7'b0100000; end
      4'd8: f3 = 3'b010;
      4'd9: f3 = 3'b011;
      default: f3 = 3'b000;
    endcase
  end

  // Legality check and word packing for the tuple currently presented
  always_comb begin
    imm_fits = (op_imm[12] == op_imm[11]);
    is_shift = (op_alu == 4'd5) || (op_alu == 4'd6) || (op_alu == 4'd7);
    legal    = 1'b0;
    enc      = 32'h0;
    case (op_cls)
      3'd0: begin
        legal = (op_alu <= 4'd9);
        enc   = {f7, op_rs2, op_rs1, f3, op_rd, OPC_R};
      end
      3'd1: begin
        legal = (op_alu <= 4'd9) && (op_alu != 4'd1) && imm_fits;
        enc   = is_shift ? {f7, op_imm[4:0], op_rs1, f3, op_rd, OPC_I}
                         : {op_imm[11:0], op_rs1, f3, op_rd, OPC_I};
      end
      3'd2: begin
        legal = imm_fits;
        enc   = {op_imm[11:0], op_rs1, 3'b010, op_rd, OPC_LOAD};
      end
      3'd3: begin
        legal = imm_fits;
        enc   = {op_imm[11:5], op_rs2, op_rs1, 3'b010, op_imm[4:0], OPC_STORE};
      end
      3'd4: begin
        legal = !op_imm[0] && !op_alu[3] && (op_alu[2:1] != 2'b01);
        enc   = {op_imm[12], op_imm[10:5], op_rs2, op_rs1, op_alu[2:0],
                 op_imm[4:1], op_imm[11], OPC_BRANCH};
      end
      default: begin
        legal = 1'b0;
        enc   = 32'h0;
      end
    endcase
  end

  logic              accept;
  logic              we_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [31:0]       wdata_nxt;
  logic [WC_W-1:0]   wc_nxt;
  logic [WC_W-1:0]   wc_inc;
  logic              err_nxt;
  logic              ovf_nxt;
  logic              ready_nxt;
  logic              busy_nxt;
  logic              done_nxt;

  // Next-state and next-output logic; all outputs are registered below
  always_comb begin
    state_nxt = state;
    we_nxt    = 1'b0;
    addr_nxt  = imem_addr;
    wdata_nxt = imem_wdata;
    wc_nxt    = word_count;
    err_nxt   = err;
    ovf_nxt   = overflow;
    wc_inc    = WC_W'(word_count + 16'd1);
    accept    = (state == S_RUN) && op_valid && op_ready;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = S_RUN;
          addr_nxt  = '0;
          wc_nxt    = '0;
          err_nxt   = 1'b0;
          ovf_nxt   = 1'b0;
        end
      end
      S_RUN: begin
        if (accept) begin
          if (legal) begin
            we_nxt    = 1'b1;
            addr_nxt  = ADDR_W'({word_count, 2'b00});
            wdata_nxt = enc;
            wc_nxt    = wc_inc;
            if (wc_inc == LAST_SLOT) begin
              ovf_nxt   = 1'b1;
              state_nxt = S_FLUSH;
            end
          end else begin
            err_nxt = 1'b1;
          end
          if (op_last) state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        we_nxt    = 1'b1;
        addr_nxt  = ADDR_W'({word_count, 2'b00});
        wdata_nxt = HALT_WORD;
        wc_nxt    = wc_inc;
        state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
    ready_nxt = (state_nxt == S_RUN) && (wc_nxt < LAST_SLOT);
    busy_nxt  = (state_nxt == S_RUN) || (state_nxt == S_FLUSH);
    done_nxt  = (state_nxt == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      op_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      overflow   <= 1'b0;
      word_count <= '0;
    end else begin
      state      <= state_nxt;
      op_ready   <= ready_nxt;
      imem_we    <= we_nxt;
      imem_addr  <= addr_nxt;
      imem_wdata <= wdata_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      err        <= err_nxt;
      overflow   <= ovf_nxt;
      word_count <= wc_nxt;
    end
  end

endmodule
